mem_arbiter: RTL and testbench

Single-cycle arbiter that shares the unified instruction/data memory between three requesters:
- debug/loader port (D)
- CPU data port for lw/sw (L)
- CPU instruction-fetch port (F)

It sits between the CPU core and a synchronous single-port SRAM with 1-cycle read latency. This lets the CPU move from the combinational `mem[pc]` / `mem[alu_out]` model to a real RAM, stalling on lost arbitration. Fixed priority D > L > F, with a starvation guard that promotes F over L.

---
 rtl/mem_arbiter.sv | 124 ++++++++++++
 tb/tb_mem_arbiter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shares one synchronous single-port SRAM between debug/loader (D), CPU data (L)
// and CPU fetch (F) ports: fixed priority D > L > F with a starvation promotion for F.
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  input  logic                  d_hold,
  input  logic                  l_req,
  input  logic                  l_we,
  input  logic [ADDR_WIDTH-1:0] l_addr,
  input  logic [DATA_WIDTH-1:0] l_wdata,
  output logic                  l_gnt,
  output logic                  l_rvalid,
  output logic [DATA_WIDTH-1:0] l_rdata,
  input  logic                  f_req,
  input  logic [ADDR_WIDTH-1:0] f_addr,
  output logic                  f_gnt,
  output logic                  f_rvalid,
  output logic [DATA_WIDTH-1:0] f_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int unsigned CNT_WIDTH = 4;
  localparam int unsigned NUM_PORTS = 3;
  localparam logic [CNT_WIDTH-1:0] STARVE_MAX = CNT_WIDTH'(STARVE_LIMIT);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] RDRET = 1'b1;

  logic [0:0]           state, state_nxt;
  logic [NUM_PORTS-1:0] rsel, rsel_nxt;
  logic [CNT_WIDTH-1:0] starve_cnt, starve_nxt;
  logic                 f_starved;

  // State register: read-return tracking and fetch starvation count
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      rsel       <= '0;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      rsel       <= rsel_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  // Grant selection; reset and d_hold gate the CPU ports
  always_comb begin
    d_gnt     = 1'b0;
    l_gnt     = 1'b0;
    f_gnt     = 1'b0;
    f_starved = f_req && (starve_cnt == STARVE_MAX);
    if (!RST) begin
      if (d_req) begin
        d_gnt = 1'b1;
      end else if (!d_hold) begin
        if (f_starved)  f_gnt = 1'b1;
        else if (l_req) l_gnt = 1'b1;
        else if (f_req) f_gnt = 1'b1;
      end
    end
  end

  // Winner drives the SRAM; idle bus is all zeros
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (d_gnt) begin
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (l_gnt) begin
      mem_en    = 1'b1;
      mem_we    = l_we;
      mem_addr  = l_addr;
      mem_wdata = l_wdata;
    end else if (f_gnt) begin
      mem_en    = 1'b1;
      mem_addr  = f_addr;
    end
  end

  // Next state: rsel records the read grantee; starvation counter update
  always_comb begin
    state_nxt  = IDLE;
    rsel_nxt   = {f_gnt, l_gnt && !l_we, d_gnt && !d_we};
    starve_nxt = starve_cnt;
    if (|rsel_nxt) state_nxt = RDRET;
    if (f_gnt || !f_req) begin
      starve_nxt = '0;
    end else if (l_gnt && (starve_cnt < STARVE_MAX)) begin
      starve_nxt = starve_cnt + CNT_WIDTH'(1);
    end
  end

  // Read return; masked during reset so a read granted just before reset is dropped
  always_comb begin
    d_rvalid = (state == RDRET) && rsel[0] && !RST;
    l_rvalid = (state == RDRET) && rsel[1] && !RST;
    f_rvalid = (state == RDRET) && rsel[2] && !RST;
    d_rdata  = mem_rdata;
    l_rdata  = mem_rdata;
    f_rdata  = mem_rdata;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 1-cycle-latency SRAM.
module tb_mem_arbiter;

  logic        CLK;
  logic        RST;
  logic        d_req, d_we, d_gnt, d_rvalid, d_hold;
  logic [15:0] d_addr, d_wdata, d_rdata;
  logic        l_req, l_we, l_gnt, l_rvalid;
  logic [15:0] l_addr, l_wdata, l_rdata;
  logic        f_req, f_gnt, f_rvalid;
  logic [15:0] f_addr, f_rdata;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  logic [15:0] sram [0:255];
  int checks = 0;
  int errors = 0;

  mem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .STARVE_LIMIT(3)) dut (
    .CLK(CLK), .RST(RST),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_hold(d_hold),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .f_req(f_req), .f_addr(f_addr),
    .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // SRAM model: preload word 5 during reset, write on strobe, registered read
  always @(posedge CLK) begin
    if (RST) sram[5] <= 16'hA123;
    if (mem_en && mem_we)  sram[mem_addr[7:0]] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= sram[mem_addr[7:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1; d_hold = 1'b0;
    d_req = 1'b1; l_req = 1'b1; f_req = 1'b1;
    d_we = 1'b0; l_we = 1'b0;
    d_addr = 16'h0005; l_addr = 16'h0005; f_addr = 16'h0005;
    d_wdata = '0; l_wdata = '0;

    // Reset with every request high
    repeat (2) begin
      @(negedge CLK);
      chk("rst_d_gnt", 32'(d_gnt), 32'd0);
      chk("rst_l_gnt", 32'(l_gnt), 32'd0);
      chk("rst_f_gnt", 32'(f_gnt), 32'd0);
      chk("rst_mem_en", 32'(mem_en), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_rvalid", 32'({d_rvalid, l_rvalid, f_rvalid}), 32'd0);
    end
    step; RST = 1'b0;
    @(negedge CLK);
    chk("rel_d_gnt", 32'(d_gnt), 32'd1);
    chk("rel_lf_gnt", 32'({l_gnt, f_gnt}), 32'd0);
    chk("rel_mem_addr", 32'(mem_addr), 32'h5);
    step; d_req = 1'b0; l_req = 1'b0; f_req = 1'b0;
    @(negedge CLK);
    chk("rel_d_rvalid", 32'(d_rvalid), 32'd1);
    chk("rel_d_rdata", 32'(d_rdata), 32'hA123);
    chk("idle_mem_en", 32'(mem_en), 32'd0);
    chk("idle_mem_addr", 32'(mem_addr), 32'd0);

    // Single fetch
    step; f_req = 1'b1; f_addr = 16'h0005;
    @(negedge CLK);
    chk("fetch_gnt", 32'(f_gnt), 32'd1);
    chk("fetch_mem_en", 32'(mem_en), 32'd1);
    chk("fetch_mem_we", 32'(mem_we), 32'd0);
    chk("fetch_mem_addr", 32'(mem_addr), 32'h5);
    step; f_req = 1'b0;
    @(negedge CLK);
    chk("fetch_rvalid", 32'(f_rvalid), 32'd1);
    chk("fetch_rdata", 32'(f_rdata), 32'hA123);
    chk("fetch_other_rvalid", 32'({d_rvalid, l_rvalid}), 32'd0);

    // L write then read of the same address
    step; l_req = 1'b1; l_we = 1'b1; l_addr = 16'h0010; l_wdata = 16'hBEEF;
    @(negedge CLK);
    chk("sw_gnt", 32'(l_gnt), 32'd1);
    chk("sw_mem_we", 32'(mem_we), 32'd1);
    chk("sw_mem_addr", 32'(mem_addr), 32'h10);
    chk("sw_mem_wdata", 32'(mem_wdata), 32'hBEEF);
    step; l_we = 1'b0;
    @(negedge CLK);
    chk("lw_gnt", 32'(l_gnt), 32'd1);
    chk("lw_no_rvalid_after_sw", 32'(l_rvalid), 32'd0);
    chk("lw_mem_we", 32'(mem_we), 32'd0);
    step; l_req = 1'b0;
    @(negedge CLK);
    chk("lw_rvalid", 32'(l_rvalid), 32'd1);
    chk("lw_rdata", 32'(l_rdata), 32'hBEEF);

    // Starvation: L and F both requesting every cycle
    step; l_req = 1'b1; f_req = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      chk("starve_f_gnt", 32'(f_gnt), 32'((c == 3) || (c == 7)));
      chk("starve_l_gnt", 32'(l_gnt), 32'((c != 3) && (c != 7)));
      if (c == 1) chk("starve_l_rvalid", 32'(l_rvalid), 32'd1);
      if (c == 4) begin
        chk("starve_f_rvalid", 32'(f_rvalid), 32'd1);
        chk("starve_f_rdata", 32'(f_rdata), 32'hA123);
      end
      step;
    end

    // Debug hold with one D write; starvation count (2) must survive the hold
    d_hold = 1'b1; d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0020; d_wdata = 16'h1234;
    @(negedge CLK);
    chk("hold_d_gnt", 32'(d_gnt), 32'd1);
    chk("hold_lf_gnt", 32'({l_gnt, f_gnt}), 32'd0);
    chk("hold_mem_we", 32'(mem_we), 32'd1);
    step; d_req = 1'b0;
    repeat (2) begin
      @(negedge CLK);
      chk("hold_no_gnt", 32'({d_gnt, l_gnt, f_gnt}), 32'd0);
      chk("hold_mem_en", 32'(mem_en), 32'd0);
      step;
    end
    d_hold = 1'b0;
    @(negedge CLK);
    chk("unhold_l_first", 32'(l_gnt), 32'd1);
    chk("unhold_f_wait", 32'(f_gnt), 32'd0);
    step;
    @(negedge CLK);
    chk("unhold_f_promoted", 32'(f_gnt), 32'd1);
    chk("unhold_l_lost", 32'(l_gnt), 32'd0);
    step; l_req = 1'b0; f_req = 1'b0; d_req = 1'b1; d_we = 1'b0;
    @(negedge CLK);
    chk("dread_gnt", 32'(d_gnt), 32'd1);
    step; d_req = 1'b0;
    @(negedge CLK);
    chk("dread_rvalid", 32'(d_rvalid), 32'd1);
    chk("dread_rdata", 32'(d_rdata), 32'h1234);

    // Reset arriving the cycle after a fetch read grant
    step; f_req = 1'b1; f_addr = 16'h0005;
    @(negedge CLK);
    chk("midrst_f_gnt", 32'(f_gnt), 32'd1);
    step; RST = 1'b1; f_req = 1'b0;
    @(negedge CLK);
    chk("midrst_rvalid_n1", 32'(f_rvalid), 32'd0);
    chk("midrst_mem_en", 32'(mem_en), 32'd0);
    step; RST = 1'b0;
    @(negedge CLK);
    chk("midrst_rvalid_n2", 32'({d_rvalid, l_rvalid, f_rvalid}), 32'd0);
    step;
    @(negedge CLK);
    chk("midrst_rvalid_n3", 32'({d_rvalid, l_rvalid, f_rvalid}), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
